// File: rtl/glitch_sweeper.sv
// ----------------------------------------------------------------------------
// glitch_sweeper
//
// Sequencer for the glitch delayer. A start command walks a 2-D grid of
// (delay, width) points, with width in the inner loop and delay in the outer
// loop. For each point it presents the values, arms the delayer trigger path
// for exactly one shot, waits for that shot to finish, then advances.
//
// Optional feature macro: GLITCH_SWEEP_REPEAT_EN
//   defined     : i_REPEAT port exists, and each point fires max(i_REPEAT,1) times
//   not defined : each point fires exactly once
//
// Ports
//   i_CLK, i_RST_N       clock, asynchronous active-low reset
//   i_START, i_ABORT     sweep start pulse (IDLE only) / abort (highest priority)
//   i_DELAY_*            delay axis start/stop/step, sampled at start
//   i_WIDTH_*            width axis start/stop/step, sampled at start
//   i_REPEAT             shots per point (macro only)
//   i_RUN                delayer run status, high while a shot is in progress
//   o_DELAY, o_WIDTH     current point presented to the delayer
//   o_ARM                trigger-path enable
//   o_BUSY               high outside IDLE
//   o_DONE               one-cycle pulse on normal completion
//   o_SHOT_CNT           completed shots in the current/last sweep
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a start, trigger path closed
// ARMED | point presented, trigger path open, waiting for i_RUN rise
// FIRE  | shot in progress, waiting for i_RUN to fall
// STEP  | count the shot and pick the next point (or finish)
// DONE  | one-cycle completion pulse
// ----------------------------------------------------------------------------
module glitch_sweeper #(
    parameter int CNT_W = 32
`ifdef GLITCH_SWEEP_REPEAT_EN
    , parameter int REP_W = 16
`endif
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_START,
    input  logic             i_ABORT,
    input  logic [CNT_W-1:0] i_DELAY_START,
    input  logic [CNT_W-1:0] i_DELAY_STOP,
    input  logic [CNT_W-1:0] i_DELAY_STEP,
    input  logic [CNT_W-1:0] i_WIDTH_START,
    input  logic [CNT_W-1:0] i_WIDTH_STOP,
    input  logic [CNT_W-1:0] i_WIDTH_STEP,
`ifdef GLITCH_SWEEP_REPEAT_EN
    input  logic [REP_W-1:0] i_REPEAT,
`endif
    input  logic             i_RUN,
    output logic [CNT_W-1:0] o_DELAY,
    output logic [CNT_W-1:0] o_WIDTH,
    output logic             o_ARM,
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic [CNT_W-1:0] o_SHOT_CNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_FIRE  = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             run_prev_q;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] shot_cnt_q, shot_cnt_d;
    logic [CNT_W-1:0] d_stop_q, d_stop_d;
    logic [CNT_W-1:0] d_step_q, d_step_d;
    logic [CNT_W-1:0] w_start_q, w_start_d;
    logic [CNT_W-1:0] w_stop_q, w_stop_d;
    logic [CNT_W-1:0] w_step_q, w_step_d;

    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   d_sum;
    logic             w_adv_ok;
    logic             d_adv_ok;
    logic             rep_more;
    logic             start_ok;

`ifdef GLITCH_SWEEP_REPEAT_EN
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_n_q, rep_n_d;
    logic [REP_W-1:0] rep_max;
`endif

    // Sums are one bit wider so a carry out of CNT_W bits is visible and
    // blocks the advance instead of wrapping back to a small value.
    always_comb begin
        w_sum    = {1'b0, width_q} + {1'b0, w_step_q};
        d_sum    = {1'b0, delay_q} + {1'b0, d_step_q};
        w_adv_ok = (w_step_q != '0) && !w_sum[CNT_W] && (w_sum <= {1'b0, w_stop_q});
        d_adv_ok = (d_step_q != '0) && !d_sum[CNT_W] && (d_sum <= {1'b0, d_stop_q});
        start_ok = i_START && (i_WIDTH_START != '0);
    end

`ifdef GLITCH_SWEEP_REPEAT_EN
    always_comb begin
        rep_max  = (rep_n_q == '0) ? {{(REP_W-1){1'b0}}, 1'b1} : rep_n_q;
        rep_more = (rep_q < rep_max);
    end
`else
    assign rep_more = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        width_d    = width_q;
        shot_cnt_d = shot_cnt_q;
        d_stop_d   = d_stop_q;
        d_step_d   = d_step_q;
        w_start_d  = w_start_q;
        w_stop_d   = w_stop_q;
        w_step_d   = w_step_q;
`ifdef GLITCH_SWEEP_REPEAT_EN
        rep_d      = rep_q;
        rep_n_d    = rep_n_q;
`endif

        if (i_ABORT) begin
            // Abort leaves the point values and shot count where they were.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        d_stop_d   = i_DELAY_STOP;
                        d_step_d   = i_DELAY_STEP;
                        w_start_d  = i_WIDTH_START;
                        w_stop_d   = i_WIDTH_STOP;
                        w_step_d   = i_WIDTH_STEP;
                        delay_d    = i_DELAY_START;
                        width_d    = i_WIDTH_START;
                        shot_cnt_d = '0;
`ifdef GLITCH_SWEEP_REPEAT_EN
                        rep_n_d    = i_REPEAT;
                        rep_d      = {{(REP_W-1){1'b0}}, 1'b1};
`endif
                        state_d    = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (i_RUN && !run_prev_q) begin
                        state_d = S_FIRE;
                    end
                end
                S_FIRE: begin
                    if (!i_RUN) begin
                        state_d = S_STEP;
                    end
                end
                S_STEP: begin
                    shot_cnt_d = shot_cnt_q + 1'b1;
                    state_d    = S_ARMED;
                    if (rep_more) begin
`ifdef GLITCH_SWEEP_REPEAT_EN
                        rep_d = rep_q + 1'b1;
`endif
                    end else if (w_adv_ok) begin
`ifdef GLITCH_SWEEP_REPEAT_EN
                        rep_d = {{(REP_W-1){1'b0}}, 1'b1};
`endif
                        width_d = w_sum[CNT_W-1:0];
                    end else if (d_adv_ok) begin
`ifdef GLITCH_SWEEP_REPEAT_EN
                        rep_d = {{(REP_W-1){1'b0}}, 1'b1};
`endif
                        width_d = w_start_q;
                        delay_d = d_sum[CNT_W-1:0];
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= S_IDLE;
            run_prev_q <= 1'b0;
            delay_q    <= '0;
            width_q    <= '0;
            shot_cnt_q <= '0;
            d_stop_q   <= '0;
            d_step_q   <= '0;
            w_start_q  <= '0;
            w_stop_q   <= '0;
            w_step_q   <= '0;
`ifdef GLITCH_SWEEP_REPEAT_EN
            rep_q      <= {{(REP_W-1){1'b0}}, 1'b1};
            rep_n_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            run_prev_q <= i_RUN;
            delay_q    <= delay_d;
            width_q    <= width_d;
            shot_cnt_q <= shot_cnt_d;
            d_stop_q   <= d_stop_d;
            d_step_q   <= d_step_d;
            w_start_q  <= w_start_d;
            w_stop_q   <= w_stop_d;
            w_step_q   <= w_step_d;
`ifdef GLITCH_SWEEP_REPEAT_EN
            rep_q      <= rep_d;
            rep_n_q    <= rep_n_d;
`endif
        end
    end

    // Status outputs decode straight from the state register so that an
    // asynchronous reset clears them without waiting for a clock edge.
    assign o_ARM      = (state_q == S_ARMED);
    assign o_BUSY     = (state_q != S_IDLE);
    assign o_DONE     = (state_q == S_DONE);
    assign o_DELAY    = delay_q;
    assign o_WIDTH    = width_q;
    assign o_SHOT_CNT = shot_cnt_q;

endmodule
